// File: rtl/uhf_tx_sram_arbiter.sv
// Two-requester arbiter for the UHF TX packet SRAM APB port: frame-builder writes
// and serializer reads, one byte per APB transfer, with wait-state timeout.
module uhf_tx_sram_arbiter #(
    parameter logic [19:0] ADDR_BASE      = 20'h00000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          FIXED_WR_PRIO  = 1'b0
) (
    input  logic        i_PCLK,
    input  logic        i_Reset_all,
    input  logic        i_wr_req,
    input  logic [12:0] i_wr_addr,
    input  logic [7:0]  i_wr_data,
    output logic        o_wr_ack,
    input  logic        i_rd_req,
    input  logic [12:0] i_rd_addr,
    output logic        o_rd_ack,
    output logic [7:0]  o_rd_data,
    output logic        o_xfer_err,
    output logic        o_err_sticky,
    output logic [1:0]  o_err_code,
    input  logic        i_err_clear,
    output logic        o_busy,
    output logic [19:0] o_PADDR_SRAM,
    output logic        o_PSEL_SRAM,
    output logic        o_PENABLE_SRAM,
    output logic        o_PWRITE_SRAM,
    output logic [7:0]  o_PWDATA_SRAM,
    input  logic [7:0]  i_PRDATA_SRAM,
    input  logic        i_PREADY_SRAM,
    input  logic        i_PSLVERR_SRAM
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] CODE_SLVERR  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    state_t      state, state_n;
    grant_t      last_grant, last_grant_n;
    logic [7:0]  cnt, cnt_n;
    logic [19:0] paddr, paddr_n;
    logic        psel, psel_n;
    logic        penable, penable_n;
    logic        pwrite, pwrite_n;
    logic [7:0]  pwdata, pwdata_n;
    logic        wr_ack, wr_ack_n;
    logic        rd_ack, rd_ack_n;
    logic [7:0]  rd_data, rd_data_n;
    logic        xfer_err, xfer_err_n;
    logic        err_sticky, err_sticky_n;
    logic [1:0]  err_code, err_code_n;
    logic        busy, busy_n;

    logic        take_wr, take_rd;
    logic        done, fail;
    logic [1:0]  fail_code;
    logic [12:0] grant_addr;

    always_ff @(posedge i_PCLK) begin
        if (i_Reset_all) begin
            state      <= S_IDLE;
            last_grant <= GRANT_READ;
            cnt        <= '0;
            paddr      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_data    <= '0;
            xfer_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_code   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            paddr      <= paddr_n;
            psel       <= psel_n;
            penable    <= penable_n;
            pwrite     <= pwrite_n;
            pwdata     <= pwdata_n;
            wr_ack     <= wr_ack_n;
            rd_ack     <= rd_ack_n;
            rd_data    <= rd_data_n;
            xfer_err   <= xfer_err_n;
            err_sticky <= err_sticky_n;
            err_code   <= err_code_n;
            busy       <= busy_n;
        end
    end

    // Write wins when alone, under fixed priority, or when read had the last grant.
    always_comb begin
        take_wr    = i_wr_req && (!i_rd_req || FIXED_WR_PRIO || (last_grant == GRANT_READ));
        take_rd    = i_rd_req && !take_wr;
        grant_addr = take_wr ? i_wr_addr : i_rd_addr;
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        paddr_n      = paddr;
        psel_n       = psel;
        penable_n    = penable;
        pwrite_n     = pwrite;
        pwdata_n     = pwdata;
        wr_ack_n     = 1'b0;
        rd_ack_n     = 1'b0;
        rd_data_n    = rd_data;
        xfer_err_n   = 1'b0;
        err_sticky_n = err_sticky;
        err_code_n   = err_code;
        busy_n       = busy;
        done         = 1'b0;
        fail         = 1'b0;
        fail_code    = '0;

        if (i_err_clear) begin
            err_sticky_n = 1'b0;
            err_code_n   = '0;
        end

        case (state)
            S_IDLE: begin
                if (take_wr || take_rd) begin
                    state_n      = S_SETUP;
                    psel_n       = 1'b1;
                    penable_n    = 1'b0;
                    busy_n       = 1'b1;
                    pwrite_n     = take_wr;
                    paddr_n      = ADDR_BASE + {7'b0, grant_addr};
                    pwdata_n     = take_wr ? i_wr_data : '0;
                    last_grant_n = take_wr ? GRANT_WRITE : GRANT_READ;
                end
            end
            S_SETUP: begin
                state_n   = S_ACCESS;
                penable_n = 1'b1;
            end
            S_ACCESS: begin
                if (i_PREADY_SRAM) begin
                    done = 1'b1;
                    if (i_PSLVERR_SRAM) begin
                        fail      = 1'b1;
                        fail_code = CODE_SLVERR;
                    end else if (!pwrite) begin
                        rd_data_n = i_PRDATA_SRAM;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    done      = 1'b1;
                    fail      = 1'b1;
                    fail_code = CODE_TIMEOUT;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (done) begin
            state_n    = S_IDLE;
            psel_n     = 1'b0;
            penable_n  = 1'b0;
            busy_n     = 1'b0;
            cnt_n      = '0;
            paddr_n    = '0;
            pwrite_n   = 1'b0;
            pwdata_n   = '0;
            wr_ack_n   = pwrite;
            rd_ack_n   = !pwrite;
            xfer_err_n = fail;
        end

        // Applied after the clear so a same-cycle failure is never lost.
        if (fail) begin
            err_sticky_n = 1'b1;
            err_code_n   = fail_code;
        end
    end

    assign o_wr_ack       = wr_ack;
    assign o_rd_ack       = rd_ack;
    assign o_rd_data      = rd_data;
    assign o_xfer_err     = xfer_err;
    assign o_err_sticky   = err_sticky;
    assign o_err_code     = err_code;
    assign o_busy         = busy;
    assign o_PADDR_SRAM   = paddr;
    assign o_PSEL_SRAM    = psel;
    assign o_PENABLE_SRAM = penable;
    assign o_PWRITE_SRAM  = pwrite;
    assign o_PWDATA_SRAM  = pwdata;

endmodule
